// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_pkg;

    typedef enum logic [4:0] {
        ST_FETCH  = 5'b00001,
        ST_DECODE = 5'b00010,
        ST_EXEC   = 5'b00100,
        ST_MEM    = 5'b01000,
        ST_WB     = 5'b10000
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // ALU operation codes, shared with the ALU
    localparam logic [4:0] ALU_ADDU = 5'd0;
    localparam logic [4:0] ALU_SUBU = 5'd1;
    localparam logic [4:0] ALU_ORI  = 5'd2;
    localparam logic [4:0] ALU_LW   = 5'd3;
    localparam logic [4:0] ALU_SW   = 5'd4;
    localparam logic [4:0] ALU_LUI  = 5'd5;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_RS     = 1'b1;

    localparam logic [2:0] SRCB_RT     = 3'd0;
    localparam logic [2:0] SRCB_FOUR   = 3'd1;
    localparam logic [2:0] SRCB_SEXT   = 3'd2;
    localparam logic [2:0] SRCB_ZEXT   = 3'd3;
    localparam logic [2:0] SRCB_BRANCH = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic       ADDR_PC     = 1'b0;
    localparam logic       ADDR_ALUOUT = 1'b1;

    typedef enum logic [3:0] {
        IC_NOP,
        IC_ADDU,
        IC_SUBU,
        IC_ORI,
        IC_LUI,
        IC_LW,
        IC_SW,
        IC_BEQ,
        IC_J,
        IC_ILLEGAL
    } iclass_e;

    function automatic logic is_rtype(input iclass_e c);
        return (c == IC_ADDU) || (c == IC_SUBU);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational instruction classifier for the control FSM
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr_i,
    output iclass_e     iclass_o
);

    always_comb begin
        iclass_o = IC_ILLEGAL;
        // all-zero word is the canonical nop and wins over the R-type decode
        if (instr_i == 32'd0) begin
            iclass_o = IC_NOP;
        end else begin
            case (instr_i[31:26])
                OP_RTYPE: begin
                    if (instr_i[5:0] == FN_ADDU) begin
                        iclass_o = IC_ADDU;
                    end else if (instr_i[5:0] == FN_SUBU) begin
                        iclass_o = IC_SUBU;
                    end
                end
                OP_ORI:  iclass_o = IC_ORI;
                OP_LUI:  iclass_o = IC_LUI;
                OP_LW:   iclass_o = IC_LW;
                OP_SW:   iclass_o = IC_SW;
                OP_BEQ:  iclass_o = IC_BEQ;
                OP_J:    iclass_o = IC_J;
                default: iclass_o = IC_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional retired/cycles counters are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src_sel,
    output logic [4:0]  alu_op,
    output logic        alu_srca_sel,
    output logic [2:0]  alu_srcb_sel,
    output logic        aluout_we,
    output logic        reg_we,
    output logic        reg_dst_sel,
    output logic        mem_to_reg,
    output logic        illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] retired,
    output logic [PERF_W-1:0] cycles
`endif
);

    state_e  state_q;
    state_e  state_d;
    iclass_e iclass;

    mc_decode u_decode (
        .instr_i  (instr),
        .iclass_o (iclass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (iclass == IC_NOP || iclass == IC_ILLEGAL) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (iclass)
                    IC_LW, IC_SW:                     state_d = ST_MEM;
                    IC_ADDU, IC_SUBU, IC_ORI, IC_LUI: state_d = ST_WB;
                    default:                          state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (iclass == IC_SW) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs are forced low while reset is high so an abort drops mem_req at once.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src_sel   = PCSRC_ALU;
        alu_op       = ALU_ADDU;
        alu_srca_sel = SRCA_PC;
        alu_srcb_sel = SRCB_RT;
        aluout_we    = 1'b0;
        reg_we       = 1'b0;
        reg_dst_sel  = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req      = 1'b1;
                    alu_srcb_sel = SRCB_FOUR;
                    ir_we        = mem_ready;
                    pc_we        = mem_ready;
                end
                ST_DECODE: begin
                    alu_srcb_sel = SRCB_BRANCH;
                    aluout_we    = 1'b1;
                    illegal      = (iclass == IC_ILLEGAL);
                end
                ST_EXEC: begin
                    alu_srca_sel = SRCA_RS;
                    case (iclass)
                        IC_ADDU: begin
                            alu_srcb_sel = SRCB_RT;
                            aluout_we    = 1'b1;
                        end
                        IC_SUBU: begin
                            alu_srcb_sel = SRCB_RT;
                            alu_op       = ALU_SUBU;
                            aluout_we    = 1'b1;
                        end
                        IC_ORI: begin
                            alu_srcb_sel = SRCB_ZEXT;
                            alu_op       = ALU_ORI;
                            aluout_we    = 1'b1;
                        end
                        IC_LUI: begin
                            alu_srcb_sel = SRCB_ZEXT;
                            alu_op       = ALU_LUI;
                            aluout_we    = 1'b1;
                        end
                        IC_LW: begin
                            alu_srcb_sel = SRCB_SEXT;
                            alu_op       = ALU_LW;
                            aluout_we    = 1'b1;
                        end
                        IC_SW: begin
                            alu_srcb_sel = SRCB_SEXT;
                            alu_op       = ALU_SW;
                            aluout_we    = 1'b1;
                        end
                        IC_BEQ: begin
                            alu_srcb_sel = SRCB_RT;
                            alu_op       = ALU_SUBU;
                            pc_src_sel   = PCSRC_ALUOUT;
                            pc_we        = zero;
                        end
                        IC_J: begin
                            pc_src_sel   = PCSRC_JUMP;
                            pc_we        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_ALUOUT;
                    mem_we       = (iclass == IC_SW);
                end
                ST_WB: begin
                    reg_we      = 1'b1;
                    reg_dst_sel = is_rtype(iclass);
                    mem_to_reg  = (iclass == IC_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] retired_q;
    logic [PERF_W-1:0] retired_d;
    logic [PERF_W-1:0] cycles_q;
    logic [PERF_W-1:0] cycles_d;
    logic              retire;

    // Waiting in FETCH is not a completion; an illegal drop back to FETCH is not either.
    assign retire = (state_q != ST_FETCH) && (state_d == ST_FETCH) &&
                    !((state_q == ST_DECODE) && (iclass == IC_ILLEGAL));

    assign retired_d = retire ? retired_q + PERF_W'(1) : retired_q;
    assign cycles_d  = cycles_q + PERF_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            retired_q <= retired_d;
            cycles_q  <= cycles_d;
        end
    end

    assign retired = retired_q;
    assign cycles  = cycles_q;
`else
    logic unused_perf_w;
    assign unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl (counter checks with MC_CTRL_PERF_EN)
module tb_mc_ctrl;

    localparam int PW = 4;

    localparam int K_NOP  = 0;
    localparam int K_ILL  = 1;
    localparam int K_ADDU = 2;
    localparam int K_SUBU = 3;
    localparam int K_ORI  = 4;
    localparam int K_LUI  = 5;
    localparam int K_LW   = 6;
    localparam int K_SW   = 7;
    localparam int K_BEQ  = 8;
    localparam int K_J    = 9;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src_sel;
        logic [4:0] alu_op;
        logic       alu_srca_sel;
        logic [2:0] alu_srcb_sel;
        logic       aluout_we;
        logic       reg_we;
        logic       reg_dst_sel;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src_sel;
    logic [4:0]  alu_op;
    logic        alu_srca_sel;
    logic [2:0]  alu_srcb_sel;
    logic        aluout_we;
    logic        reg_we;
    logic        reg_dst_sel;
    logic        mem_to_reg;
    logic        illegal;
`ifdef MC_CTRL_PERF_EN
    logic [PW-1:0] retired;
    logic [PW-1:0] cycles;
    logic [PW-1:0] exp_retired;
    logic [PW-1:0] exp_cycles;
`endif

    int   checks;
    int   errors;
    exp_t exp_q[$];

    mc_ctrl #(.PERF_W(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src_sel   (pc_src_sel),
        .alu_op       (alu_op),
        .alu_srca_sel (alu_srca_sel),
        .alu_srcb_sel (alu_srcb_sel),
        .aluout_we    (aluout_we),
        .reg_we       (reg_we),
        .reg_dst_sel  (reg_dst_sel),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal)
`ifdef MC_CTRL_PERF_EN
        ,
        .retired      (retired),
        .cycles       (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t v_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_req      = 1'b1;
        c.alu_srcb_sel = 3'd1;
        c.ir_we        = rdy;
        c.pc_we        = rdy;
        return c;
    endfunction

    function automatic ctl_t v_decode(input logic ill);
        ctl_t c = '0;
        c.alu_srcb_sel = 3'd4;
        c.aluout_we    = 1'b1;
        c.illegal      = ill;
        return c;
    endfunction

    function automatic ctl_t v_exec(input int kind, input logic z);
        ctl_t c = '0;
        c.alu_srca_sel = 1'b1;
        case (kind)
            K_ADDU: begin c.alu_srcb_sel = 3'd0; c.alu_op = 5'd0; c.aluout_we = 1'b1; end
            K_SUBU: begin c.alu_srcb_sel = 3'd0; c.alu_op = 5'd1; c.aluout_we = 1'b1; end
            K_ORI:  begin c.alu_srcb_sel = 3'd3; c.alu_op = 5'd2; c.aluout_we = 1'b1; end
            K_LUI:  begin c.alu_srcb_sel = 3'd3; c.alu_op = 5'd5; c.aluout_we = 1'b1; end
            K_LW:   begin c.alu_srcb_sel = 3'd2; c.alu_op = 5'd3; c.aluout_we = 1'b1; end
            K_SW:   begin c.alu_srcb_sel = 3'd2; c.alu_op = 5'd4; c.aluout_we = 1'b1; end
            K_BEQ:  begin c.alu_srcb_sel = 3'd0; c.alu_op = 5'd1; c.pc_src_sel = 2'd1; c.pc_we = z; end
            K_J:    begin c.pc_src_sel = 2'd2; c.pc_we = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t v_mem(input logic is_sw);
        ctl_t c = '0;
        c.mem_req      = 1'b1;
        c.mem_addr_sel = 1'b1;
        c.mem_we       = is_sw;
        return c;
    endfunction

    function automatic ctl_t v_wb(input int kind);
        ctl_t c = '0;
        c.reg_we      = 1'b1;
        c.reg_dst_sel = (kind == K_ADDU) || (kind == K_SUBU);
        c.mem_to_reg  = (kind == K_LW);
        return c;
    endfunction

    // Monitor: one scoreboard entry describes the outputs of one clock period.
    ctl_t act;
    exp_t cur;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src_sel, alu_op,
                   alu_srca_sel, alu_srcb_sel, aluout_we, reg_we, reg_dst_sel,
                   mem_to_reg, illegal};
            checks++;
            if (act !== cur.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", cur.tag, act, cur.v);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic z, input ctl_t v, input string tag);
        exp_t e;
        mem_ready = rdy;
        zero      = z;
        e.v       = v;
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

`ifdef MC_CTRL_PERF_EN
    always @(posedge clk or posedge reset) begin
        if (reset) exp_cycles <= '0;
        else       exp_cycles <= exp_cycles + PW'(1);
    end

    task automatic check_cnt(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
`endif

    // mem_ready is held high in states without a request to prove it is ignored there.
    task automatic run_instr(input logic [31:0] ins, input int kind, input int fwait,
                             input int mwait, input logic z, input string nm);
        instr = ins;
        repeat (fwait) cyc(1'b0, z, v_fetch(1'b0), {nm, " fetch-wait"});
        cyc(1'b1, z, v_fetch(1'b1), {nm, " fetch"});
        cyc(1'b1, z, v_decode(kind == K_ILL), {nm, " decode"});
        if (kind != K_NOP && kind != K_ILL) begin
            cyc(1'b1, z, v_exec(kind, z), {nm, " exec"});
            if (kind == K_LW || kind == K_SW) begin
                repeat (mwait) cyc(1'b0, z, v_mem(kind == K_SW), {nm, " mem-wait"});
                cyc(1'b1, z, v_mem(kind == K_SW), {nm, " mem"});
            end
            if (kind == K_ADDU || kind == K_SUBU || kind == K_ORI || kind == K_LUI || kind == K_LW)
                cyc(1'b1, z, v_wb(kind), {nm, " wb"});
        end
`ifdef MC_CTRL_PERF_EN
        if (kind != K_ILL) exp_retired = exp_retired + PW'(1);
        check_cnt({nm, " retired"}, retired, exp_retired);
        check_cnt({nm, " cycles"}, cycles, exp_cycles);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        instr     = 32'd0;
        zero      = 1'b0;
        mem_ready = 1'b0;
`ifdef MC_CTRL_PERF_EN
        exp_retired = '0;
`endif
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, '0, "reset held ready=1");
        cyc(1'b0, 1'b0, '0, "reset held");
`ifdef MC_CTRL_PERF_EN
        check_cnt("reset retired", retired, '0);
        check_cnt("reset cycles", cycles, '0);
`endif
        reset = 1'b0;

        run_instr(32'h0085_1021, K_ADDU, 0, 0, 1'b0, "addu");
        run_instr(32'h0085_1023, K_SUBU, 1, 0, 1'b1, "subu");
        run_instr(32'h34A5_00FF, K_ORI,  0, 0, 1'b0, "ori");
        run_instr(32'h3C0A_1234, K_LUI,  0, 0, 1'b0, "lui");
        run_instr(32'h8C88_0004, K_LW,   0, 2, 1'b0, "lw");
        run_instr(32'hAC88_0008, K_SW,   2, 0, 1'b0, "sw");
        run_instr(32'h1085_FFFF, K_BEQ,  0, 0, 1'b1, "beq taken");
        run_instr(32'h1085_FFFF, K_BEQ,  0, 0, 1'b0, "beq not-taken");
        run_instr(32'h0800_0010, K_J,    0, 0, 1'b0, "j");
        run_instr(32'hFC00_0000, K_ILL,  0, 0, 1'b0, "illegal op");
        run_instr(32'h0000_0020, K_ILL,  0, 0, 1'b0, "illegal funct");
        run_instr(32'h0000_0000, K_NOP,  0, 0, 1'b0, "nop");

        // Abort a store that is waiting in MEM; the ready seen during reset is dropped.
        instr = 32'hAC88_0008;
        cyc(1'b1, 1'b0, v_fetch(1'b1), "rst-sw fetch");
        cyc(1'b1, 1'b0, v_decode(1'b0), "rst-sw decode");
        cyc(1'b1, 1'b0, v_exec(K_SW, 1'b0), "rst-sw exec");
        cyc(1'b0, 1'b0, v_mem(1'b1), "rst-sw mem-wait");
        reset = 1'b1;
        cyc(1'b1, 1'b0, '0, "rst-sw abort");
        cyc(1'b1, 1'b0, '0, "rst-sw held");
        reset = 1'b0;
`ifdef MC_CTRL_PERF_EN
        exp_retired = '0;
`endif
        cyc(1'b0, 1'b0, v_fetch(1'b0), "rst-sw post fetch");
        run_instr(32'h0085_1021, K_ADDU, 0, 0, 1'b0, "post-rst addu");

`ifdef MC_CTRL_PERF_EN
        reset = 1'b1;
        cyc(1'b0, 1'b0, '0, "wrap reset");
        reset = 1'b0;
        exp_retired = '0;
        for (int i = 0; i < 16; i++) run_instr(32'd0, K_NOP, 0, 0, 1'b0, "wrap nop");
        check_cnt("wrap retired", retired, 4'd0);
        check_cnt("wrap cycles", cycles, 4'd0);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
